uart_image_loader: RTL and testbench

- Upstream stage of the MLP classifier. Receives one 28x28 8-bit greyscale image over a UART serial line.
- Writes the pixels sequentially into the classifier's image RAM through a write port.
- Raises image_valid when a complete, well-formed frame is stored, so the classifier can be started from hardware instead of a preloaded hex file.

---
 rtl/mnist_pkg.sv | 15 +
 rtl/uart_rx.sv | 97 +++++++++
 rtl/uart_image_loader.sv | 165 ++++++++++++++++
 tb/tb_uart_image_loader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mnist_pkg.sv
// Constants shared by the MNIST image loader and the classifier: frame states, image geometry, sync byte.
package mnist_pkg;

   typedef enum logic [1:0] {
      S_HUNT  = 2'd0,
      S_LOAD  = 2'd1,
      S_CHECK = 2'd2,
      S_READY = 2'd3
   } state_t;

   localparam int         NUM_PIXELS    = 784;
   localparam int         PIX_ADDR_W    = 10;
   localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a 2-FF input synchroniser and a glitch-rejecting start check at mid-bit.
// rx_valid/rx_ferr are one-cycle pulses after the stop-bit centre sample; there is no backpressure.
module uart_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic       rx_valid,
   output logic [7:0] rx_byte,
   output logic       rx_ferr
);
   import mnist_pkg::*;

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   rx_state_t     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          meta_q, sync_q, prev_q;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (prev_q && !sync_q) state_d = RX_START;
         end
         RX_START: begin
            // A line that is high again at mid-start-bit was only a glitch.
            if (cnt_q == HALF) begin
               cnt_d   = '0;
               bit_d   = '0;
               state_d = sync_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt_q == FULL) begin
               cnt_d   = '0;
               shift_d = {sync_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt_q == FULL) begin
               cnt_d   = '0;
               state_d = RX_IDLE;
               valid_d = sync_q;
               ferr_d  = !sync_q;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         prev_q  <= 1'b1;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         meta_q  <= rxd;
         sync_q  <= meta_q;
         prev_q  <= sync_q;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign rx_valid = valid_q;
   assign rx_byte  = shift_q;
   assign rx_ferr  = ferr_q;

endmodule

// File: rtl/uart_image_loader.sv
// Receives a SYNC-prefixed image frame over UART and writes it to image RAM, 1 cycle from byte to pix_we.
// No backpressure: bytes arriving while a stored image is pending are dropped. UART_LOADER_CHECKSUM_EN adds a sum trailer.
module uart_image_loader #(
   parameter int         CLK_HZ       = 50_000_000,
   parameter int         BAUD         = 115_200,
   parameter int         NUM_PIXELS   = mnist_pkg::NUM_PIXELS,
   parameter int         ADDR_W       = mnist_pkg::PIX_ADDR_W,
   parameter logic [7:0] SYNC_BYTE    = mnist_pkg::DEF_SYNC_BYTE,
   parameter int         TIMEOUT_CLKS = 5_000_000
) (
   input  logic              CLOCK_50,
   input  logic              reset_n,
   input  logic              uart_rxd,
   output logic              pix_we,
   output logic [ADDR_W-1:0] pix_addr,
   output logic [7:0]        pix_data,
   output logic              image_valid,
   input  logic              image_consumed,
   output logic              frame_err,
   output logic              busy
);
   import mnist_pkg::*;

   localparam int                CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int                TW           = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR    = ADDR_W'(NUM_PIXELS - 1);
   localparam logic [TW-1:0]     TIMEOUT_LAST = TW'(TIMEOUT_CLKS - 1);

   logic       rx_valid, rx_ferr;
   logic [7:0] rx_byte;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk      (CLOCK_50),
      .rst_n    (reset_n),
      .rxd      (uart_rxd),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte),
      .rx_ferr  (rx_ferr)
   );

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        data_q, data_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic              busy_q, busy_d;
`ifdef UART_LOADER_CHECKSUM_EN
   logic [7:0]        sum_q, sum_d;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      timer_d = timer_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      err_d   = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      sum_d   = sum_q;
`endif
      case (state_q)
         S_HUNT: begin
            cnt_d   = '0;
            timer_d = '0;
            if (rx_valid && rx_byte == SYNC_BYTE) begin
               state_d = S_LOAD;
`ifdef UART_LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
            end
         end
         S_LOAD: begin
            timer_d = timer_q + TW'(1);
            // A SYNC_BYTE here is ordinary pixel data; resync only happens from S_HUNT.
            if (rx_valid) begin
               timer_d = '0;
               we_d    = 1'b1;
               addr_d  = cnt_q;
               data_d  = rx_byte;
               cnt_d   = cnt_q + ADDR_W'(1);
`ifdef UART_LOADER_CHECKSUM_EN
               sum_d   = sum_q + rx_byte;
`endif
               if (cnt_q == LAST_ADDR) begin
                  cnt_d = '0;
`ifdef UART_LOADER_CHECKSUM_EN
                  state_d = S_CHECK;
`else
                  state_d = S_READY;
`endif
               end
            end else if (rx_ferr || timer_q == TIMEOUT_LAST) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_HUNT;
            end
         end
`ifdef UART_LOADER_CHECKSUM_EN
         S_CHECK: begin
            timer_d = timer_q + TW'(1);
            if (rx_valid) begin
               timer_d = '0;
               if (rx_byte == sum_q) begin
                  state_d = S_READY;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_HUNT;
               end
            end else if (rx_ferr || timer_q == TIMEOUT_LAST) begin
               err_d   = 1'b1;
               state_d = S_HUNT;
            end
         end
`endif
         S_READY: begin
            if (image_consumed) state_d = S_HUNT;
         end
         default: state_d = S_HUNT;
      endcase
      valid_d = (state_d == S_READY);
      busy_d  = (state_d == S_LOAD) || (state_d == S_CHECK);
   end

   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_HUNT;
         cnt_q   <= '0;
         timer_q <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
         sum_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         timer_q <= timer_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
`ifdef UART_LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
`endif
      end
   end

   assign pix_we      = we_q;
   assign pix_addr    = addr_q;
   assign pix_data    = data_q;
   assign image_valid = valid_q;
   assign frame_err   = err_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_uart_image_loader.sv
// Bench for uart_image_loader at a scaled-down bit rate and image size; byte-level reference model.
module tb_uart_image_loader;

   localparam int         CPB  = 8;
   localparam int         NPIX = 40;
   localparam int         AW   = 6;
   localparam int         TMO  = 300;
   localparam logic [7:0] SYNC = 8'hA5;

   localparam int M_HUNT = 0, M_PIX = 1, M_TRAIL = 2, M_HOLD = 3;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          uart_rxd = 1'b1;
   logic          image_consumed = 1'b0;
   logic          pix_we, image_valid, frame_err, busy;
   logic [AW-1:0] pix_addr;
   logic [7:0]    pix_data;

   always #5 clk = ~clk;

   uart_image_loader #(
      .CLK_HZ       (CPB * 200),
      .BAUD         (200),
      .NUM_PIXELS   (NPIX),
      .ADDR_W       (AW),
      .SYNC_BYTE    (SYNC),
      .TIMEOUT_CLKS (TMO)
   ) dut (
      .CLOCK_50       (clk),
      .reset_n        (reset_n),
      .uart_rxd       (uart_rxd),
      .pix_we         (pix_we),
      .pix_addr       (pix_addr),
      .pix_data       (pix_data),
      .image_valid    (image_valid),
      .image_consumed (image_consumed),
      .frame_err      (frame_err),
      .busy           (busy)
   );

   int checks = 0;
   int failures = 0;
   int we_cnt = 0;
   int err_cnt = 0;

   // Reference model state: what the loader should be doing at byte granularity.
   int                m_mode = M_HUNT;
   int                m_idx = 0;
   int                m_err = 0;
   logic [7:0]        m_sum = 8'h00;
   logic [AW+7:0]     exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_byte(input logic [7:0] b, input bit ok);
      case (m_mode)
         M_HUNT: if (ok && b == SYNC) begin
            m_mode = M_PIX; m_idx = 0; m_sum = 8'h00;
         end
         M_PIX: if (!ok) begin
            m_err++; m_mode = M_HUNT;
         end else begin
            exp_q.push_back({AW'(m_idx), b});
            m_sum = m_sum + b;
            m_idx++;
`ifdef UART_LOADER_CHECKSUM_EN
            if (m_idx == NPIX) m_mode = M_TRAIL;
`else
            if (m_idx == NPIX) m_mode = M_HOLD;
`endif
         end
         M_TRAIL: if (!ok || b != m_sum) begin
            m_err++; m_mode = M_HUNT;
         end else m_mode = M_HOLD;
         default: ;
      endcase
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ok);
      model_byte(b, ok);
      uart_rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rxd = ok;
      repeat (CPB) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (CPB) @(negedge clk);
   endtask

   // kind: 0 ramp, 1 all 0xFF, 2 random, 3 ramp with a corrupted trailer.
   task automatic send_frame(input int kind);
      logic [7:0] p;
      send_byte(SYNC, 1'b1);
      for (int k = 0; k < NPIX; k++) begin
         case (kind)
            1:       p = 8'hFF;
            2:       p = 8'($urandom);
            default: p = 8'(k);
         endcase
         send_byte(p, 1'b1);
      end
`ifdef UART_LOADER_CHECKSUM_EN
      send_byte(m_sum + ((kind == 3) ? 8'd1 : 8'd0), 1'b1);
`endif
   endtask

   task automatic consume(input string name);
      check({name, "_valid_before"}, {31'd0, image_valid}, 32'd1);
      image_consumed = 1'b1;
      @(negedge clk);
      image_consumed = 1'b0;
      if (m_mode == M_HOLD) m_mode = M_HUNT;
      check({name, "_valid_after"}, {31'd0, image_valid}, (m_mode == M_HOLD) ? 32'd1 : 32'd0);
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, "_we"},    {31'd0, pix_we},      32'd0);
      check({name, "_addr"},  32'(pix_addr),        32'd0);
      check({name, "_data"},  32'(pix_data),        32'd0);
      check({name, "_valid"}, {31'd0, image_valid}, 32'd0);
      check({name, "_err"},   {31'd0, frame_err},   32'd0);
      check({name, "_busy"},  {31'd0, busy},        32'd0);
   endtask

   always @(negedge clk) begin
      logic [AW+7:0] w;
      if (reset_n && pix_we) begin
         we_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL write_unexpected: got addr=%0d data=%0h expected no write", pix_addr, pix_data);
         end else begin
            w = exp_q.pop_front();
            if ({pix_addr, pix_data} !== w) begin
               failures++;
               $display("FAIL write_content: got addr=%0d data=%0h expected addr=%0d data=%0h",
                        pix_addr, pix_data, w[AW+7:8], w[7:0]);
            end
         end
      end
      if (reset_n && frame_err) err_cnt++;
   end

   typedef struct {
      logic [7:0] b;
      bit         ok;
      int         we;
      int         err;
      bit         busy;
   } vec_t;

   initial begin
      vec_t vt[8];
      int   we0, err0;

      vt[0] = '{8'h00, 1'b1, 0, 0, 1'b0};
      vt[1] = '{8'h5A, 1'b1, 0, 0, 1'b0};
      vt[2] = '{8'hA5, 1'b0, 0, 0, 1'b0};
      vt[3] = '{8'hA5, 1'b1, 0, 0, 1'b1};
      vt[4] = '{8'h11, 1'b1, 1, 0, 1'b1};
      vt[5] = '{8'hA5, 1'b1, 1, 0, 1'b1};
      vt[6] = '{8'h22, 1'b0, 0, 1, 1'b0};
      vt[7] = '{8'h33, 1'b1, 0, 0, 1'b0};

      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         we0 = we_cnt; err0 = err_cnt;
         send_byte(vt[i].b, vt[i].ok);
         check($sformatf("vec%0d_we", i),   32'(we_cnt - we0),   32'(vt[i].we));
         check($sformatf("vec%0d_err", i),  32'(err_cnt - err0), 32'(vt[i].err));
         check($sformatf("vec%0d_busy", i), {31'd0, busy},       {31'd0, vt[i].busy});
      end

      // Short low glitch must not start a byte.
      uart_rxd = 1'b0;
      repeat (2) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      check("glitch_busy", {31'd0, busy}, 32'd0);

      we0 = we_cnt; err0 = err_cnt;
      send_frame(0);
      check("ramp_writes", 32'(we_cnt - we0), NPIX);
      check("ramp_valid",  {31'd0, image_valid}, 32'd1);
      check("ramp_busy",   {31'd0, busy}, 32'd0);
      check("ramp_err",    32'(err_cnt), 32'(m_err));

      we0 = we_cnt;
      send_frame(1);
      check("protect_writes", 32'(we_cnt - we0), 32'd0);
      check("protect_valid",  {31'd0, image_valid}, 32'd1);
      consume("consume1");

      we0 = we_cnt;
      send_byte(8'h00, 1'b1);
      send_byte(8'h5A, 1'b1);
      send_frame(2);
      check("rand_writes", 32'(we_cnt - we0), NPIX);
      check("rand_valid",  {31'd0, image_valid}, 32'd1);
      consume("consume2");

      err0 = err_cnt;
      send_byte(SYNC, 1'b1);
      for (int k = 0; k < 15; k++) send_byte(8'($urandom), 1'b1);
      send_byte(8'h44, 1'b0);
      check("ferr_err",   32'(err_cnt - err0), 32'd1);
      check("ferr_busy",  {31'd0, busy}, 32'd0);
      send_frame(0);
      check("after_ferr_valid", {31'd0, image_valid}, 32'd1);
      consume("consume3");

      err0 = err_cnt;
      send_byte(SYNC, 1'b1);
      for (int k = 0; k < 20; k++) send_byte(8'($urandom), 1'b1);
      repeat (TMO + 10) @(negedge clk);
      if (m_mode == M_PIX || m_mode == M_TRAIL) begin
         m_err++; m_mode = M_HUNT;
      end
      check("tmo_err",   32'(err_cnt - err0), 32'd1);
      check("tmo_valid", {31'd0, image_valid}, 32'd0);
      check("tmo_total_err", 32'(err_cnt), 32'(m_err));

      send_byte(SYNC, 1'b1);
      for (int k = 0; k < 10; k++) send_byte(8'(k + 100), 1'b1);
      check("prerst_busy", {31'd0, busy}, 32'd1);
      reset_n = 1'b0;
      #1;
      check_outputs_zero("midrst");
      m_mode = M_HUNT;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

`ifdef UART_LOADER_CHECKSUM_EN
      err0 = err_cnt;
      send_frame(3);
      check("badsum_err",   32'(err_cnt - err0), 32'd1);
      check("badsum_valid", {31'd0, image_valid}, 32'd0);
      send_frame(0);
      check("goodsum_valid", {31'd0, image_valid}, 32'd1);
      check("goodsum_total_err", 32'(err_cnt), 32'(m_err));
`endif

      check("pending_writes", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
